// File: rtl/maze_pkg.sv
// Shared definitions for the maze frame buffer.
// Holds the geometry (cell address / data widths), the cell colour codes,
// the clear value and the controller state encoding.
package maze_pkg;

    localparam int AW     = 6;          // cell address width, row = addr[5:3], col = addr[2:0]
    localparam int DW     = 2;          // bicolor cell width
    localparam int NCELLS = 1 << AW;    // cells per buffer

    localparam logic [DW-1:0] C_OFF = 2'b00;
    localparam logic [DW-1:0] C_RED = 2'b01;
    localparam logic [DW-1:0] C_GRN = 2'b10;
    localparam logic [DW-1:0] C_ORG = 2'b11;

    localparam logic [DW-1:0] CLR_VAL = C_OFF;

    typedef enum logic [1:0] {
        INIT_CLR = 2'd0,
        RUN      = 2'd1,
        CLR      = 2'd2
    } fb_state_t;

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port RAM backing both frame buffers.
// Ports:
//   clk, nrst        clock, async active-low reset (read register only)
//   we, waddr, wdata synchronous write port
//   re, raddr        read request and address
//   rdata            registered read data, holds while re=0
// The array itself carries no reset so it can map onto block RAM.
module fb_dpram
    import maze_pkg::*;
#(
    parameter int ADDR_W = AW + 1,
    parameter int DATA_W = DW
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/maze_frame_buffer.sv
// Double-buffered 8x8 bicolor frame store.
// The display scanner reads the front buffer (address/command -> data, latency 1);
// game logic writes the back buffer through a valid/ready port.
// Ports:
//   clk, nrst                  clock, async active-low reset
//   address, command, data     scan read port on the front buffer
//   wr_valid, wr_ready,        back-buffer write port
//   wr_addr, wr_data
//   clr_start                  pulse: clear back buffer to CLR_VAL
//   swap_req                   pulse: request a front/back exchange
//   swap_done                  one-cycle pulse when the exchange takes effect
//   busy                       high while a clear (initial or requested) runs
//   dbg_state                  current controller state (fb_state_t encoding)
// Handshake: a write transfers on a rising edge where wr_valid & wr_ready are
// both high; wr_valid may be held across wr_ready=0 and the write then waits.
module maze_frame_buffer
    import maze_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    input  logic [AW-1:0] address,
    input  logic          command,
    output logic [DW-1:0] data,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          clr_start,
    input  logic          swap_req,
    output logic          swap_done,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    fb_state_t     state;
    logic [AW:0]   clr_cnt;      // spans both buffers during the initial clear
    logic          front;
    logic          swap_pending;
    logic          swap_fire;

    logic          mem_we;
    logic [AW:0]   mem_waddr;
    logic [DW-1:0] mem_wdata;

    assign dbg_state = state;

    // The swap lands on the read of the last cell, so that read still sees
    // the old front and the next frame starts cleanly on the new one.
    assign swap_fire = swap_pending & command & (address == '1) & (state == RUN);

    // Write port: clears own the port while busy, game writes otherwise.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = CLR_VAL;
        case (state)
            INIT_CLR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
            end
            CLR: begin
                mem_we    = 1'b1;
                mem_waddr = {~front, clr_cnt[AW-1:0]};
            end
            RUN: begin
                mem_we    = wr_valid;
                mem_waddr = {~front, wr_addr};
                mem_wdata = wr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= INIT_CLR;
            clr_cnt      <= '0;
            busy         <= 1'b1;
            wr_ready     <= 1'b0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            swap_done <= swap_fire;
            if (swap_fire) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end

            case (state)
                INIT_CLR: begin
                    if (clr_cnt == '1) begin
                        clr_cnt  <= '0;
                        state    <= RUN;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_start) begin
                        clr_cnt  <= '0;
                        state    <= CLR;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end
                end
                CLR: begin
                    if (clr_cnt[AW-1:0] == '1) begin
                        clr_cnt  <= '0;
                        state    <= RUN;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    clr_cnt  <= '0;
                    state    <= INIT_CLR;
                    busy     <= 1'b1;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    fb_dpram #(.ADDR_W(AW + 1), .DATA_W(DW)) u_ram (
        .clk   (clk),
        .nrst  (nrst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (command),
        .raddr ({front, address}),
        .rdata (data)
    );

endmodule

// File: tb/tb_maze_frame_buffer.sv
module tb_maze_frame_buffer;

    logic       clk;
    logic       nrst;
    logic [5:0] address;
    logic       command;
    logic [1:0] data;
    logic       wr_valid;
    logic       wr_ready;
    logic [5:0] wr_addr;
    logic [1:0] wr_data;
    logic       clr_start;
    logic       swap_req;
    logic       swap_done;
    logic       busy;
    logic [1:0] dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    maze_frame_buffer dut (
        .clk       (clk),
        .nrst      (nrst),
        .address   (address),
        .command   (command),
        .data      (data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_start (clr_start),
        .swap_req  (swap_req),
        .swap_done (swap_done),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    // Two plain 64-cell arrays plus a front index. A clear wipes the whole back
    // buffer at once (nothing can read the back buffer while it is clearing),
    // and busy is just a count of remaining clear cycles.
    logic [1:0] m_buf [2][64];
    bit         m_front;
    bit         m_pending;
    int         m_busy_left;
    logic [1:0] m_data;
    bit         m_sd;

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 64; i++) m_buf[b][i] = 2'b00;
        m_front     = 0;
        m_pending   = 0;
        m_busy_left = 128;
        m_data      = 2'b00;
        m_sd        = 0;
    endtask

    task automatic model_edge();
        bit         is_busy;
        bit         fire;
        logic [1:0] rd;
        is_busy = (m_busy_left > 0);
        rd = command ? m_buf[m_front][address] : m_data;
        if (wr_valid && !is_busy) m_buf[!m_front][wr_addr] = wr_data;
        fire = m_pending && command && (address == 6'd63) && !is_busy;
        m_sd = fire;
        if (fire) begin
            m_front   = !m_front;
            m_pending = 0;
        end else if (swap_req) begin
            m_pending = 1;
        end
        if (is_busy) begin
            m_busy_left--;
        end else if (clr_start) begin
            m_busy_left = 64;
            for (int i = 0; i < 64; i++) m_buf[!m_front][i] = 2'b00;
        end
        m_data = rd;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // One clock: model steps with the inputs in force, DUT is sampled 1ns after the edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("data",      8'(data),      8'(m_data));
        chk("busy",      8'(busy),      8'(m_busy_left > 0));
        chk("wr_ready",  8'(wr_ready),  8'(m_busy_left == 0));
        chk("swap_done", 8'(swap_done), 8'(m_sd));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        command = 0; address = '0; wr_valid = 0; wr_addr = '0;
        wr_data = '0; clr_start = 0; swap_req = 0;
    endtask

    task automatic drive(input logic cmd, input logic [5:0] a, input logic wv,
                         input logic [5:0] wa, input logic [1:0] wd,
                         input logic sr, input logic cs);
        command = cmd; address = a; wr_valid = wv; wr_addr = wa;
        wr_data = wd; swap_req = sr; clr_start = cs;
    endtask

    task automatic count_busy(output int cyc);
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            step();
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic       cmd;
        logic [5:0] addr;
        logic       wv;
        logic [5:0] wa;
        logic [1:0] wd;
        logic       sreq;
        logic [1:0] e_data;
        logic       e_sd;
    } vec_t;

    vec_t tbl [17];

    initial begin
        int cyc;
        int sd_cnt;

        tbl[0]  = '{0,  0, 1, 9, 2'b01, 0, 2'b00, 0};
        tbl[1]  = '{1,  9, 0, 0, 2'b00, 0, 2'b00, 0};
        tbl[2]  = '{1,  9, 1, 5, 2'b11, 0, 2'b00, 0};
        tbl[3]  = '{1,  5, 0, 0, 2'b00, 1, 2'b00, 0};
        tbl[4]  = '{1, 63, 0, 0, 2'b00, 0, 2'b00, 1};
        tbl[5]  = '{1,  9, 0, 0, 2'b00, 0, 2'b01, 0};
        tbl[6]  = '{1,  5, 0, 0, 2'b00, 0, 2'b11, 0};
        tbl[7]  = '{1,  9, 1, 9, 2'b10, 0, 2'b01, 0};
        tbl[8]  = '{1, 63, 0, 0, 2'b00, 1, 2'b00, 0};
        tbl[9]  = '{1, 63, 0, 0, 2'b00, 0, 2'b00, 1};
        tbl[10] = '{1,  9, 0, 0, 2'b00, 0, 2'b10, 0};
        tbl[11] = '{1,  5, 0, 0, 2'b00, 0, 2'b00, 0};
        tbl[12] = '{1,  9, 0, 0, 2'b00, 0, 2'b10, 0};
        tbl[13] = '{0,  5, 0, 0, 2'b00, 0, 2'b10, 0};
        tbl[14] = '{0,  0, 0, 0, 2'b00, 1, 2'b10, 0};
        tbl[15] = '{1, 63, 0, 0, 2'b00, 1, 2'b00, 1};
        tbl[16] = '{1,  9, 0, 0, 2'b00, 0, 2'b01, 0};

        // ---- reset and initial clear ----
        idle_inputs();
        nrst = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",      8'(data),      8'h0);
        chk("rst_busy",      8'(busy),      8'h1);
        chk("rst_wr_ready",  8'(wr_ready),  8'h0);
        chk("rst_swap_done", 8'(swap_done), 8'h0);
        nrst = 1;
        count_busy(cyc);
        chk("init_busy_cycles", 8'(cyc), 8'd128);
        step();
        step();
        for (int a = 0; a < 64; a++) begin
            drive(1, 6'(a), 0, 0, 0, 0, 0);
            step();
            chk("init_read_zero", 8'(data), 8'h0);
        end

        // ---- table: writes, reads, swaps, hold, repeated swap_req ----
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].cmd, tbl[i].addr, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].sreq, 0);
            step();
            chk($sformatf("tbl%0d_data", i), 8'(data), 8'(tbl[i].e_data));
            chk($sformatf("tbl%0d_swap_done", i), 8'(swap_done), 8'(tbl[i].e_sd));
        end

        // ---- write held through a requested clear ----
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        drive(0, 0, 1, 0, 2'b10, 0, 0);
        cyc = 0;
        while (!wr_ready && cyc < 200) begin
            cyc++;
            step();
        end
        chk("clr_hold_cycles", 8'(cyc), 8'd64);
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 63, 0, 0, 0, 0, 0);
        step();
        chk("clr_swap_done", 8'(swap_done), 8'h1);
        drive(1, 0, 0, 0, 0, 0, 0);
        step();
        chk("held_write_landed", 8'(data), 8'h2);

        // ---- swap requested, then clear before the frame end ----
        drive(0, 0, 1, 3, 2'b11, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 1);
        step();
        sd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            drive(1, 63, 0, 0, 0, 0, 0);
            step();
            if (swap_done) sd_cnt++;
        end
        chk("no_swap_while_clearing", 8'(sd_cnt), 8'h0);
        chk("clear_ended", 8'(busy), 8'h0);
        step();
        chk("deferred_swap_done", 8'(swap_done), 8'h1);
        drive(1, 3, 0, 0, 0, 0, 0);
        step();
        chk("write_before_clear_wiped", 8'(data), 8'h0);

        // ---- reset mid-clear ----
        drive(0, 0, 1, 7, 2'b11, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 63, 0, 0, 0, 0, 0);
        step();
        drive(1, 7, 0, 0, 0, 0, 0);
        step();
        chk("pre_reset_data", 8'(data), 8'h3);
        drive(0, 0, 0, 0, 0, 1, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (20) step();
        nrst = 0;
        #1;
        chk("midrst_data",      8'(data),      8'h0);
        chk("midrst_busy",      8'(busy),      8'h1);
        chk("midrst_wr_ready",  8'(wr_ready),  8'h0);
        chk("midrst_swap_done", 8'(swap_done), 8'h0);
        model_reset();
        @(posedge clk);
        #1;
        nrst = 1;
        count_busy(cyc);
        chk("reinit_busy_cycles", 8'(cyc), 8'd128);
        drive(1, 63, 0, 0, 0, 0, 0);
        step();
        chk("pending_lost", 8'(swap_done), 8'h0);

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 1500; i++) begin
            command   = ($urandom_range(0, 3) != 0);
            address   = ($urandom_range(0, 3) == 0) ? 6'd63 : 6'($urandom_range(0, 63));
            wr_valid  = $urandom_range(0, 1);
            wr_addr   = 6'($urandom_range(0, 63));
            wr_data   = 2'($urandom_range(0, 3));
            swap_req  = ($urandom_range(0, 15) == 0);
            clr_start = ($urandom_range(0, 99) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
